// File: rtl/my_matrice_led_axi_slave.sv
// AXI4-Lite slave exposing four read/write 32-bit registers to the LED matrix logic.
// Define MATRICE_LED_ADDR_CHECK_EN to reject addresses outside 0x0..0xC with SLVERR.
module my_matrice_led_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out
);

    localparam int NumLanes = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wrState_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rdState_t;

    wrState_t                       wrState_q;
    logic                           awready_q;
    logic                           wready_q;
    logic                           bvalid_q;
    logic [1:0]                     bresp_q;

    rdState_t                       rdState_q;
    logic                           arready_q;
    logic                           rvalid_q;
    logic [1:0]                     rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata_q;

    logic [C_S_AXI_DATA_WIDTH-1:0]  regs_q [4];

    logic [1:0]                     wrIdx;
    logic [1:0]                     rdIdx;
    logic                           wrAddrOk;
    logic                           rdAddrOk;
    logic [C_S_AXI_DATA_WIDTH-1:0]  wrWord_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdWord_d;
    logic                           unusedInputs;

    assign wrIdx = S_AXI_AWADDR[3:2];
    assign rdIdx = S_AXI_ARADDR[3:2];

`ifdef MATRICE_LED_ADDR_CHECK_EN
    assign wrAddrOk = (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
    assign rdAddrOk = (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
`else
    assign wrAddrOk = 1'b1;
    assign rdAddrOk = 1'b1;
`endif

    assign unusedInputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                            S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                            S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4],
                            S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4]};

    // Byte-lane merge of the incoming write data onto the addressed register.
    always_comb begin
        wrWord_d = regs_q[wrIdx];
        for (int i = 0; i < NumLanes; i++) begin
            if (S_AXI_WSTRB[i]) begin
                wrWord_d[8*i +: 8] = S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    assign rdWord_d = rdAddrOk ? regs_q[rdIdx] : '0;

    // Write FSM: address and data are only taken together, and the register
    // commit happens on the single edge where both READYs are high.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wrState_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (wrState_q)
                W_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wrState_q <= W_ACCEPT;
                    end
                end
                W_ACCEPT: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= wrAddrOk ? RespOkay : RespSlvErr;
                    if (wrAddrOk) begin
                        regs_q[wrIdx] <= wrWord_d;
                    end
                    wrState_q <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RespOkay;
                        wrState_q <= W_IDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    wrState_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: RDATA samples the register array through non-blocking reads,
    // so a write committing on the same edge is seen by the next read only.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rdState_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            case (rdState_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        arready_q <= 1'b1;
                        rdState_q <= R_ACCEPT;
                    end
                end
                R_ACCEPT: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rdWord_d;
                    rresp_q   <= rdAddrOk ? RespOkay : RespSlvErr;
                    rdState_q <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        rresp_q   <= RespOkay;
                        rdState_q <= R_IDLE;
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    rdState_q <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign reg0_out = regs_q[0];
    assign reg1_out = regs_q[1];
    assign reg2_out = regs_q[2];
    assign reg3_out = regs_q[3];

endmodule
